bcd_countdown_timer: RTL and testbench

Parametrised N-digit BCD countdown timer; next generation of the game's two-digit round timer. Loads a per-level start time on `timerReconfig` and counts down one unit every `TICK_DIV` clocks while `timerEnable` is high, with pause/resume and bonus-time extension. Flags expiry with a one-cycle `timeout` pulse and a sticky `expired` level. Sits between the game controller, which supplies `timerReconfig`, `timerEnable`, `gameLevel` and `bonus`, and the per-digit `decoder_4to7` instances.

---
 rtl/bcd_countdown_timer.sv | 172 +++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// N-digit packed-BCD countdown timer with pause, bonus time and expiry flags.
// Loads a per-level start value, decrements once every TICK_DIV enabled clocks.
module bcd_countdown_timer #(
  parameter int NUM_DIGITS = 2,
  parameter int TICK_DIV = 1000,
  parameter logic [4*NUM_DIGITS-1:0] LOAD_L0 = 'h60,
  parameter logic [4*NUM_DIGITS-1:0] LOAD_L1 = 'h45,
  parameter logic [4*NUM_DIGITS-1:0] LOAD_L2 = 'h30,
  parameter logic [4*NUM_DIGITS-1:0] LOAD_L3 = 'h15,
  parameter logic [4*NUM_DIGITS-1:0] WARN_VAL = 'h10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    timerReconfig,
  input  logic                    timerEnable,
  input  logic [1:0]              gameLevel,
  input  logic                    bonus,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    timeout,
  output logic                    expired,
  output logic                    running,
  output logic                    warn
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [VW-1:0] ALL9 = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] value_q, value_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          timeout_q, timeout_d;
  logic [VW-1:0] load_val;
  logic [VW-1:0] dec_v;
  logic [VW-1:0] inc_v;
  logic          tick;

  function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // All-9s saturates instead of wrapping to zero.
  function automatic logic [VW-1:0] bcd_inc(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    if (v != ALL9) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (c) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign dec_v = bcd_dec(value_q);
  assign inc_v = bcd_inc(value_q);

  always_comb begin
    load_val = LOAD_L0;
    unique case (gameLevel)
      2'd0: load_val = LOAD_L0;
      2'd1: load_val = LOAD_L1;
      2'd2: load_val = LOAD_L2;
      2'd3: load_val = LOAD_L3;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    presc_d   = presc_q;
    timeout_d = 1'b0;
    tick      = 1'b0;
    if (timerReconfig) begin
      value_d = load_val;
      presc_d = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bonus) value_d = inc_v;
          if (timerEnable) begin
            if (value_q == '0 && !bonus) begin
              state_d   = EXPIRED;
              timeout_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (!timerEnable) begin
            state_d = PAUSED;
            if (bonus) value_d = inc_v;
          end else begin
            tick    = (presc_q == PW'(TICK_DIV - 1));
            presc_d = tick ? '0 : presc_q + PW'(1);
            // A tick and a bonus in the same cycle cancel out.
            if (tick && !bonus) begin
              value_d = dec_v;
              if (dec_v == '0) begin
                state_d   = EXPIRED;
                timeout_d = 1'b1;
              end
            end else if (!tick && bonus) begin
              value_d = inc_v;
            end
          end
        end
        PAUSED: begin
          if (bonus) value_d = inc_v;
          if (timerEnable) state_d = RUN;
        end
        EXPIRED: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      value_q   <= '0;
      presc_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      presc_q   <= presc_d;
      timeout_q <= timeout_d;
    end
  end

  assign digits  = value_q;
  assign timeout = timeout_q;
  assign expired = (state_q == EXPIRED);
  assign running = (state_q == RUN);
  assign warn    = (state_q == RUN || state_q == PAUSED)
                   && (value_q <= WARN_VAL);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed table-driven bench for bcd_countdown_timer (2-digit, TICK_DIV=4)
// plus a 3-digit instance for the multi-digit borrow case.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rc, en, bo;
  logic [1:0]  lvl;
  logic [7:0]  d;
  logic        to, ex, ru, wa;
  logic [11:0] d3;
  logic        to3, ex3, ru3, wa3;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(
    .NUM_DIGITS(2),
    .TICK_DIV(4),
    .LOAD_L0(8'h12),
    .LOAD_L1(8'h99),
    .LOAD_L2(8'h30),
    .LOAD_L3(8'h00),
    .WARN_VAL(8'h10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .timerReconfig(rc),
    .timerEnable(en),
    .gameLevel(lvl),
    .bonus(bo),
    .digits(d),
    .timeout(to),
    .expired(ex),
    .running(ru),
    .warn(wa)
  );

  bcd_countdown_timer #(
    .NUM_DIGITS(3),
    .TICK_DIV(2),
    .LOAD_L0(12'h100)
  ) dut3 (
    .clk(clk),
    .rst(rst),
    .timerReconfig(rc),
    .timerEnable(en),
    .gameLevel(lvl),
    .bonus(bo),
    .digits(d3),
    .timeout(to3),
    .expired(ex3),
    .running(ru3),
    .warn(wa3)
  );

  typedef struct {
    logic       rc;
    logic       en;
    logic [1:0] lvl;
    logic       bo;
    int         n;
    logic [7:0] d;
    logic       to, ex, ru, wa;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [1:0] l,
                     input logic b, input int n, input logic [7:0] xd,
                     input logic xto, input logic xex, input logic xru,
                     input logic xwa, input string name);
    vec_t v;
    v.rc = r; v.en = e; v.lvl = l; v.bo = b; v.n = n;
    v.d = xd; v.to = xto; v.ex = xex; v.ru = xru; v.wa = xwa;
    v.name = name;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got {digits,to,ex,ru,wa}=%h, want %h",
               name, act, exp);
    else
      passed++;
  endtask

  initial begin
    rst = 1'b0;
    rc = 1'b0; en = 1'b0; bo = 1'b0; lvl = 2'd0;

    //  rc en lvl bo  n   digits to ex ru wa
    add(1, 0, 2, 0,  1, 8'h30, 0, 0, 0, 0, "load_l2");
    add(1, 1, 0, 1,  1, 8'h12, 0, 0, 0, 0, "rc_with_bonus");
    add(0, 1, 0, 0,  1, 8'h12, 0, 0, 1, 0, "enter_run");
    add(0, 1, 0, 0,  3, 8'h12, 0, 0, 1, 0, "presc_3");
    add(0, 1, 0, 0,  1, 8'h11, 0, 0, 1, 0, "tick_1");
    add(0, 1, 0, 0,  4, 8'h10, 0, 0, 1, 1, "tick_2_warn");
    add(0, 1, 0, 0,  4, 8'h09, 0, 0, 1, 1, "borrow");
    add(0, 1, 0, 0,  2, 8'h09, 0, 0, 1, 1, "presc_2");
    add(0, 0, 0, 0,  1, 8'h09, 0, 0, 0, 1, "pause");
    add(0, 0, 0, 0,  9, 8'h09, 0, 0, 0, 1, "pause_hold");
    add(0, 1, 0, 0,  1, 8'h09, 0, 0, 1, 1, "resume");
    add(0, 1, 0, 0,  1, 8'h09, 0, 0, 1, 1, "resume_p3");
    add(0, 1, 0, 0,  1, 8'h08, 0, 0, 1, 1, "resume_tick");
    add(0, 1, 0, 0, 28, 8'h01, 0, 0, 1, 1, "near_zero");
    add(0, 1, 0, 0,  3, 8'h01, 0, 0, 1, 1, "last_presc");
    add(0, 1, 0, 0,  1, 8'h00, 1, 1, 0, 0, "expire");
    add(0, 1, 0, 0,  1, 8'h00, 0, 1, 0, 0, "timeout_drop");
    add(0, 1, 0, 1,  1, 8'h00, 0, 1, 0, 0, "bonus_expired");
    add(1, 0, 1, 0,  1, 8'h99, 0, 0, 0, 0, "rc_from_expired");
    add(0, 0, 1, 1,  1, 8'h99, 0, 0, 0, 0, "bonus_saturate");
    add(1, 0, 3, 0,  1, 8'h00, 0, 0, 0, 0, "load_zero");
    add(0, 1, 3, 0,  1, 8'h00, 1, 1, 0, 0, "direct_expire");
    add(1, 0, 0, 0,  1, 8'h12, 0, 0, 0, 0, "reload");
    add(0, 1, 0, 0,  1, 8'h12, 0, 0, 1, 0, "run_again");
    add(0, 1, 0, 0, 12, 8'h09, 0, 0, 1, 1, "down_to_09");
    add(0, 0, 0, 1,  1, 8'h10, 0, 0, 0, 1, "bonus_carry");
    add(0, 1, 0, 0,  1, 8'h10, 0, 0, 1, 1, "run_p0");
    add(0, 1, 0, 0,  3, 8'h10, 0, 0, 1, 1, "run_p3");
    add(0, 1, 0, 1,  1, 8'h10, 0, 0, 1, 1, "tick_plus_bonus");
    add(0, 1, 0, 0,  4, 8'h09, 0, 0, 1, 1, "after_cancel");

    repeat (2) @(posedge clk);
    #1;
    check("reset", {4'h0, d, to, ex, ru, wa}, 16'h0000);
    rst = 1'b1;

    foreach (tbl[i]) begin
      rc = tbl[i].rc; en = tbl[i].en; lvl = tbl[i].lvl; bo = tbl[i].bo;
      repeat (tbl[i].n) @(posedge clk);
      #1;
      check(tbl[i].name, {4'h0, d, to, ex, ru, wa},
            {4'h0, tbl[i].d, tbl[i].to, tbl[i].ex, tbl[i].ru, tbl[i].wa});
    end

    // Asynchronous reset in the middle of a running count.
    bo = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("async_reset", {4'h0, d, to, ex, ru, wa}, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_hold", {4'h0, d, to, ex, ru, wa}, 16'h0000);
    rst = 1'b1;

    // Three-digit borrow across two digits: 0x100 -> 0x099.
    rc = 1'b1; en = 1'b0; lvl = 2'd0;
    @(posedge clk);
    #1;
    check("d3_load", {d3, to3, ex3, ru3, wa3}, {12'h100, 4'b0000});
    rc = 1'b0; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("d3_presc", {d3, to3, ex3, ru3, wa3}, {12'h100, 4'b0010});
    @(posedge clk);
    #1;
    check("d3_borrow", {d3, to3, ex3, ru3, wa3}, {12'h099, 4'b0010});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
